// File: rtl/dmem_arb_pkg.sv
// Shared types and address constants for the DMem arbiter slice.
package dmem_arb_pkg;

    // Access sequencer states: wait, drive DMem for one cycle, return the result.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    // Read-only window: three ID words followed by the switch register.
    localparam logic [31:0] RO_BASE_DEF = 32'h0010_0000;
    localparam logic [31:0] RO_LAST_DEF = 32'h0010_0010;

    // Other well-known locations on the data bus.
    localparam logic [31:0] RAM_BASE = 32'h8000_0000;
    localparam logic [31:0] LED_ADDR = 32'h0010_0014;

    // A write is refused when it targets the read-only window, or when it is a
    // full-word write that is not word aligned.
    function automatic logic write_blocked(
        input logic [31:0] addr,
        input logic [3:0]  be,
        input logic [31:0] ro_base,
        input logic [31:0] ro_last
    );
        logic [31:0] word_addr;
        logic        in_ro;
        logic        misaligned;
        word_addr  = {addr[31:2], 2'b00};
        in_ro      = (word_addr >= ro_base) && (word_addr <= ro_last);
        misaligned = (addr[1:0] != 2'b00) && (be == 4'b1111);
        return (be != 4'b0000) && (in_ro || misaligned);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input combinational picker: round-robin on a last-granted pointer,
// or strict priority to input 0 when FIXED_PRIO is set.
module rr_arbiter2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] pick
);

    // On a tie the requester that was not granted last wins; otherwise pass through.
    always_comb begin
        pick = 2'b00;
        if (req == 2'b11) begin
            pick = ((FIXED_PRIO != 0) || ptr) ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single DMem port between the CPU load/store unit (requester 0)
// and the debug/loader port (requester 1), sequencing each access through
// DMem's one-cycle synchronous read and refusing writes to read-only words.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int          FIXED_PRIO = 0,
    parameter logic [31:0] RO_BASE    = RO_BASE_DEF,
    parameter logic [31:0] RO_LAST    = RO_LAST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [3:0]  we0,
    input  logic [3:0]  we1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic [31:0] rdata0,
    output logic [31:0] rdata1,
    output logic [31:0] addr_in,
    output logic [31:0] data_in,
    output logic [3:0]  we,
    output logic        rd,
    input  logic [31:0] data_out
);

    arb_state_t        state_reg;
    logic              ptr_reg;
    logic              owner_reg;
    logic              is_read_reg;
    logic              err_flag_reg;
    logic [31:0]       addr_in_reg;
    logic [31:0]       data_in_reg;
    logic [3:0]        we_reg;
    logic              rd_reg;
    logic [1:0]        gnt_reg;
    logic [1:0]        done_reg;
    logic [1:0]        err_reg;
    logic [1:0][31:0]  rdata_hold_reg;
    logic [1:0][31:0]  rdata_bus;

    logic [1:0]        pick;
    logic              arb_en;
    logic              latch;
    logic              win;
    logic [31:0]       sel_addr;
    logic [31:0]       sel_wdata;
    logic [3:0]        sel_we;
    logic              sel_blocked;

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_pick (
        .req  ({req1, req0}),
        .ptr  (ptr_reg),
        .pick (pick)
    );

    // Select the winner's request fields and classify the access before latching.
    always_comb begin
        arb_en      = (state_reg == IDLE) || (state_reg == RESP);
        latch       = arb_en && (pick != 2'b00);
        win         = pick[1];
        sel_addr    = win ? addr1  : addr0;
        sel_wdata   = win ? wdata1 : wdata0;
        sel_we      = win ? we1    : we0;
        sel_blocked = write_blocked(sel_addr, sel_we, RO_BASE, RO_LAST);
    end

    // Sequencer FSM; every DMem and requester-side strobe is a registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            ptr_reg        <= 1'b1;
            owner_reg      <= 1'b0;
            is_read_reg    <= 1'b0;
            err_flag_reg   <= 1'b0;
            addr_in_reg    <= '0;
            data_in_reg    <= '0;
            we_reg         <= '0;
            rd_reg         <= 1'b0;
            gnt_reg        <= '0;
            done_reg       <= '0;
            err_reg        <= '0;
            rdata_hold_reg <= '0;
        end else begin
            gnt_reg  <= '0;
            done_reg <= '0;
            err_reg  <= '0;
            we_reg   <= '0;
            rd_reg   <= 1'b0;
            case (state_reg)
                IDLE, RESP: begin
                    // Read data leaving DMem is kept so rdataN stays stable afterwards.
                    if ((state_reg == RESP) && is_read_reg) begin
                        rdata_hold_reg[owner_reg] <= data_out;
                    end
                    if (latch) begin
                        state_reg    <= ACCESS;
                        ptr_reg      <= win;
                        owner_reg    <= win;
                        is_read_reg  <= (sel_we == 4'b0000);
                        err_flag_reg <= sel_blocked;
                        gnt_reg      <= pick;
                        addr_in_reg  <= sel_addr;
                        data_in_reg  <= sel_wdata;
                        we_reg       <= sel_blocked ? 4'b0000 : sel_we;
                        rd_reg       <= (sel_we == 4'b0000);
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                ACCESS: begin
                    state_reg           <= RESP;
                    done_reg[owner_reg] <= 1'b1;
                    err_reg[owner_reg]  <= err_flag_reg;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Owner of a read sees DMem data directly in RESP; otherwise the held copy.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            assign rdata_bus[gi] = ((state_reg == RESP) && is_read_reg && (owner_reg == 1'(gi)))
                                   ? data_out : rdata_hold_reg[gi];
        end
    endgenerate

    assign gnt0    = gnt_reg[0];
    assign gnt1    = gnt_reg[1];
    assign done0   = done_reg[0];
    assign done1   = done_reg[1];
    assign err0    = err_reg[0];
    assign err1    = err_reg[1];
    assign rdata0  = rdata_bus[0];
    assign rdata1  = rdata_bus[1];
    assign addr_in = addr_in_reg;
    assign data_in = data_in_reg;
    assign we      = we_reg;
    assign rd      = rd_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a DMem model on the memory side, a transaction-level
// reference memory and arbitration model, directed cases then random traffic.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  we0, we1;
    logic        gnt0, gnt1, done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1, addr_in, data_in;
    logic [3:0]  we;
    logic        rd;
    logic [31:0] data_out;

    // Fixed-priority instance, memory side tied off.
    logic        fp_req0, fp_req1;
    logic        fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_err0, fp_err1;
    logic [31:0] fp_rdata0, fp_rdata1, fp_addr_in, fp_data_in;
    logic [3:0]  fp_we;
    logic        fp_rd;
    logic [31:0] zero32;
    assign zero32 = 32'h0;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1), .we0(we0), .we1(we1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata0(rdata0), .rdata1(rdata1),
        .addr_in(addr_in), .data_in(data_in), .we(we), .rd(rd),
        .data_out(data_out)
    );

    dmem_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst(rst),
        .req0(fp_req0), .req1(fp_req1), .addr0(32'h8000_0000), .addr1(32'h8000_0004),
        .wdata0(32'h0), .wdata1(32'h0), .we0(4'h0), .we1(4'h0),
        .gnt0(fp_gnt0), .gnt1(fp_gnt1), .done0(fp_done0), .done1(fp_done1),
        .err0(fp_err0), .err1(fp_err1), .rdata0(fp_rdata0), .rdata1(fp_rdata1),
        .addr_in(fp_addr_in), .data_in(fp_data_in), .we(fp_we), .rd(fp_rd),
        .data_out(zero32)
    );

    always #5 clk = ~clk;

    // Word index into the small memory images used here.
    function automatic int widx(input logic [31:0] a);
        return a[31] ? (8 + int'(a[5:2])) : int'(a[4:2]);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    // DMem model: one-cycle synchronous read, byte-enabled write.
    logic [31:0] dmem [0:31];
    logic        dm_ready = 1'b0;
    always @(posedge clk) begin
        if (!dm_ready) begin
            for (int i = 0; i < 32; i++) dmem[i] <= 32'h0;
            dmem[0]  <= 32'h1387_4751;
            dmem[1]  <= 32'h1870_0095;
            dmem[2]  <= 32'h1831_3324;
            dm_ready <= 1'b1;
        end else if (we != 4'h0) begin
            dmem[widx(addr_in)] <= merge(dmem[widx(addr_in)], data_in, we);
        end
        data_out <= dm_ready ? dmem[widx(addr_in)] : 32'h0;
    end

    // Reference model state.
    logic [31:0] ref_mem [0:31];
    logic [31:0] last_rd [0:1];
    int          ref_last;

    function automatic logic blocked(input logic [31:0] a, input logic [3:0] w);
        logic [31:0] wa;
        wa = a & 32'hFFFF_FFFC;
        if (w == 4'h0) return 1'b0;
        if (wa >= 32'h0010_0000 && wa <= 32'h0010_0010) return 1'b1;
        return (a[1:0] != 2'b00) && (w == 4'hF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int r, input logic v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] w);
        if (r == 0) begin req0 = v; addr0 = a; wdata0 = d; we0 = w; end
        else        begin req1 = v; addr1 = a; wdata1 = d; we1 = w; end
    endtask

    task automatic chk_access(input int r, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] w);
        logic [1:0] oh;
        oh = (r == 0) ? 2'b01 : 2'b10;
        chk("gnt", {30'h0, gnt1, gnt0}, {30'h0, oh});
        chk("done_in_access", {30'h0, done1, done0}, 32'h0);
        chk("addr_in", addr_in, a);
        chk("dmem_we", {28'h0, we}, blocked(a, w) ? 32'h0 : {28'h0, w});
        chk("rd", {31'h0, rd}, (w == 4'h0) ? 32'h1 : 32'h0);
        if (w != 4'h0) chk("data_in", data_in, d);
    endtask

    task automatic chk_resp(input int r, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] w);
        logic [1:0] oh;
        logic       b;
        oh = (r == 0) ? 2'b01 : 2'b10;
        b  = blocked(a, w);
        chk("done", {30'h0, done1, done0}, {30'h0, oh});
        chk("gnt_in_resp", {30'h0, gnt1, gnt0}, 32'h0);
        chk("err", {30'h0, err1, err0}, b ? {30'h0, oh} : 32'h0);
        chk("we_in_resp", {28'h0, we}, 32'h0);
        if (w == 4'h0) begin
            last_rd[r] = ref_mem[widx(a)];
            chk("rdata_owner", (r == 0) ? rdata0 : rdata1, last_rd[r]);
        end else if (!b) begin
            ref_mem[widx(a)] = merge(ref_mem[widx(a)], d, w);
        end
        chk("rdata_other", (r == 0) ? rdata1 : rdata0, last_rd[1 - r]);
    endtask

    task automatic chk_idle();
        chk("gnt_idle", {30'h0, gnt1, gnt0}, 32'h0);
        chk("done_idle", {30'h0, done1, done0}, 32'h0);
        chk("rdata0_hold", rdata0, last_rd[0]);
        chk("rdata1_hold", rdata1, last_rd[1]);
    endtask

    task automatic do_txn(input int r, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] w);
        drive(r, 1'b1, a, d, w);
        tick();
        chk_access(r, a, d, w);
        tick();
        drive(r, 1'b0, a, d, w);
        chk_resp(r, a, d, w);
        ref_last = r;
        tick();
        chk_idle();
        $display("txn req%0d addr=%h wdata=%h we=%h rdata0=%h rdata1=%h", r, a, d, w, rdata0, rdata1);
    endtask

    // Both requesters present at once: round-robin picks the one not granted last.
    task automatic do_pair(input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] w0,
                           input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] w1);
        logic [31:0] pa [0:1];
        logic [31:0] pd [0:1];
        logic [3:0]  pw [0:1];
        int win, lose;
        pa[0] = a0; pd[0] = d0; pw[0] = w0;
        pa[1] = a1; pd[1] = d1; pw[1] = w1;
        win  = (ref_last == 0) ? 1 : 0;
        lose = 1 - win;
        drive(0, 1'b1, a0, d0, w0);
        drive(1, 1'b1, a1, d1, w1);
        tick();
        chk_access(win, pa[win], pd[win], pw[win]);
        tick();
        drive(win, 1'b0, pa[win], pd[win], pw[win]);
        chk_resp(win, pa[win], pd[win], pw[win]);
        tick();
        chk_access(lose, pa[lose], pd[lose], pw[lose]);
        tick();
        drive(lose, 1'b0, pa[lose], pd[lose], pw[lose]);
        chk_resp(lose, pa[lose], pd[lose], pw[lose]);
        ref_last = lose;
        tick();
        chk_idle();
        $display("pair first=req%0d a0=%h we0=%h a1=%h we1=%h rdata0=%h rdata1=%h",
                 win, a0, w0, a1, w1, rdata0, rdata1);
    endtask

    function automatic logic [31:0] rand_addr();
        int s;
        s = $urandom_range(0, 3);
        if (s <= 1) return 32'h8000_0000 + 4 * $urandom_range(0, 7);
        if (s == 2) return 32'h0010_0000 + 4 * $urandom_range(0, 4);
        return 32'h8000_0000 + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
    endfunction

    function automatic logic [3:0] rand_we();
        int s;
        s = $urandom_range(0, 3);
        if (s <= 1) return 4'h0;
        if (s == 2) return 4'hF;
        return 4'($urandom_range(1, 15));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1, 1'b0, 32'h0, 32'h0, 4'h0);
        fp_req0 = 1'b0;
        fp_req1 = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
        ref_mem[0] = 32'h1387_4751;
        ref_mem[1] = 32'h1870_0095;
        ref_mem[2] = 32'h1831_3324;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        ref_last   = 1;

        // Both requesting straight out of reset.
        drive(0, 1'b1, 32'h0010_0004, 32'h0, 4'h0);
        drive(1, 1'b1, 32'h0010_0008, 32'h0, 4'h0);
        #1;
        chk("reset_gnt",   {30'h0, gnt1, gnt0}, 32'h0);
        chk("reset_done",  {30'h0, done1, done0}, 32'h0);
        chk("reset_err",   {30'h0, err1, err0}, 32'h0);
        chk("reset_rdata0", rdata0, 32'h0);
        chk("reset_rdata1", rdata1, 32'h0);
        chk("reset_addr_in", addr_in, 32'h0);
        chk("reset_data_in", data_in, 32'h0);
        chk("reset_we_rd", {27'h0, we, rd}, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        do_pair(32'h0010_0004, 32'h0, 4'h0, 32'h0010_0008, 32'h0, 4'h0);
        chk("id_word1", rdata0, 32'h1870_0095);
        chk("id_word2", rdata1, 32'h1831_3324);

        // Single read of the first ID word.
        do_txn(0, 32'h0010_0000, 32'h0, 4'h0);
        chk("id_word0", rdata0, 32'h1387_4751);

        // Requester 1 write then read back.
        do_txn(1, 32'h8000_0010, 32'hFEDC_BA98, 4'hF);
        do_txn(1, 32'h8000_0010, 32'h0, 4'h0);
        chk("readback", rdata1, 32'hFEDC_BA98);

        // Write to the switch register is refused.
        do_txn(0, 32'h0010_0010, 32'hDEAD_BEEF, 4'hF);
        do_txn(0, 32'h0010_0010, 32'h0, 4'h0);
        chk("switch_reg", rdata0, 32'h0);

        // Misaligned full-word write refused; misaligned partial write allowed.
        do_txn(1, 32'h8000_0005, 32'h1234_5678, 4'hF);
        do_txn(1, 32'h8000_0006, 32'hAABB_CCDD, 4'b1100);
        do_txn(1, 32'h8000_0004, 32'h0, 4'h0);
        chk("partial_write", rdata1, 32'hAABB_0000);

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = $urandom_range(0, 2);
            if (mode == 2)
                do_pair(rand_addr(), $urandom, rand_we(), rand_addr(), $urandom, rand_we());
            else
                do_txn(mode, rand_addr(), $urandom, rand_we());
        end

        // Reset asserted in the middle of a write access.
        drive(0, 1'b1, 32'h8000_0020, 32'h1111_1111, 4'hF);
        tick();
        chk("we_before_reset", {28'h0, we}, 32'hF);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_we", {28'h0, we}, 32'h0);
        chk("rst_mid_rd", {31'h0, rd}, 32'h0);
        chk("rst_mid_gnt", {30'h0, gnt1, gnt0}, 32'h0);
        chk("rst_mid_done", {30'h0, done1, done0}, 32'h0);
        chk("rst_mid_err", {30'h0, err1, err0}, 32'h0);
        chk("rst_mid_addr_in", addr_in, 32'h0);
        chk("rst_mid_data_in", data_in, 32'h0);
        chk("rst_mid_rdata0", rdata0, 32'h0);
        chk("rst_mid_rdata1", rdata1, 32'h0);
        drive(0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        last_rd[0] = 32'h0;
        last_rd[1] = 32'h0;
        ref_last   = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_done", {30'h0, done1, done0}, 32'h0);
            chk("post_rst_no_gnt", {30'h0, gnt1, gnt0}, 32'h0);
        end
        $display("reset during write access: outputs cleared, no done");
        do_txn(0, 32'h8000_0000, 32'h0, 4'h0);

        // Fixed priority with both continuously requesting: only requester 0.
        fp_req0 = 1'b1;
        fp_req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("fp_gnt0", {31'h0, fp_gnt0}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("fp_gnt1", {31'h0, fp_gnt1}, 32'h0);
            chk("fp_done0", {31'h0, fp_done0}, (i % 2 == 1) ? 32'h1 : 32'h0);
            $display("fixed-prio cycle %0d gnt0=%0b gnt1=%0b done0=%0b", i, fp_gnt0, fp_gnt1, fp_done0);
        end
        fp_req0 = 1'b0;
        fp_req1 = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
